// File: rtl/counter_updown_mod.sv
// Up/down counter with programmable terminal value, wrap/saturate/one-shot overflow modes,
// falling-edge state updates. Define COUNTER_PRESCALER_EN to compile in the internal prescaler.
module counter_updown_mod #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic             Clk,
   input  logic             nReset,
   input  logic             Clear,
   input  logic             Load,
   input  logic             Count_en,
   input  logic             Up,
   input  logic [1:0]       Mode,
   input  logic [WIDTH-1:0] Limit,
   input  logic [WIDTH-1:0] Count_in,
   output logic [WIDTH-1:0] Count_out,
   output logic             Tc,
   output logic             Done
);

   localparam logic [1:0] MODE_SAT = 2'b01;
   localparam logic [1:0] MODE_ONE = 2'b10;

   generate
      if (WIDTH < 2 || PRESCALE < 1) begin : g_bad_param
         $error("counter_updown_mod: WIDTH must be >= 2 and PRESCALE >= 1");
      end
   endgenerate

   logic             tick;
   logic             count_event;
   logic             boundary;
   logic             set_done;
   logic [WIDTH-1:0] next_count;

`ifdef COUNTER_PRESCALER_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pre_cnt;
   logic          pre_last;

   assign pre_last = (pre_cnt == PW'(PRESCALE - 1));
   assign tick     = pre_last;

   // Prescaler only advances on enabled edges, so Count_en low freezes it.
   always_ff @(negedge Clk or negedge nReset) begin
      if (!nReset) begin
         pre_cnt <= '0;
      end else if (Clear || Load) begin
         pre_cnt <= '0;
      end else if (Count_en) begin
         pre_cnt <= pre_last ? '0 : pre_cnt + 1'b1;
      end
   end
`else
   assign tick = 1'b1;
`endif

   // A finished one-shot stops counting until Clear/Load, or until Mode leaves one-shot.
   always_comb begin
      count_event = Count_en && tick && !(Mode == MODE_ONE && Done);
      boundary    = Up ? (Count_out >= Limit) : (Count_out == '0);
      next_count  = Count_out;
      set_done    = 1'b0;
      if (Up) begin
         if (boundary) begin
            case (Mode)
               MODE_SAT: next_count = Limit;
               MODE_ONE: begin
                  next_count = Limit;
                  set_done   = 1'b1;
               end
               default:  next_count = '0;
            endcase
         end else begin
            next_count = Count_out + 1'b1;
         end
      end else begin
         if (boundary) begin
            case (Mode)
               MODE_SAT: next_count = '0;
               MODE_ONE: begin
                  next_count = '0;
                  set_done   = 1'b1;
               end
               default:  next_count = Limit;
            endcase
         end else begin
            next_count = Count_out - 1'b1;
         end
      end
   end

   always_ff @(negedge Clk or negedge nReset) begin
      if (!nReset) begin
         Count_out <= '0;
         Tc        <= 1'b0;
         Done      <= 1'b0;
      end else if (Clear) begin
         Count_out <= '0;
         Tc        <= 1'b0;
         Done      <= 1'b0;
      end else if (Load) begin
         Count_out <= Count_in;
         Tc        <= 1'b0;
         Done      <= 1'b0;
      end else begin
         Tc <= count_event && boundary;
         if (count_event) begin
            Count_out <= next_count;
            if (set_done) begin
               Done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Self-checking bench for counter_updown_mod: directed scenarios plus a randomized
// scoreboard run against a behavioural model.
module tb_counter_updown_mod;

   localparam int W = 8;
`ifdef COUNTER_PRESCALER_EN
   localparam int PS = 4;
`else
   localparam int PS = 1;
`endif

   logic         Clk;
   logic         nReset;
   logic         Clear;
   logic         Load;
   logic         Count_en;
   logic         Up;
   logic [1:0]   Mode;
   logic [W-1:0] Limit;
   logic [W-1:0] Count_in;
   logic [W-1:0] Count_out;
   logic         Tc;
   logic         Done;

   logic [W+1:0] exp_q[$];
   int           n_checks;
   int           n_fails;

   counter_updown_mod #(.WIDTH(W), .PRESCALE(PS)) dut (
      .Clk       (Clk),
      .nReset    (nReset),
      .Clear     (Clear),
      .Load      (Load),
      .Count_en  (Count_en),
      .Up        (Up),
      .Mode      (Mode),
      .Limit     (Limit),
      .Count_in  (Count_in),
      .Count_out (Count_out),
      .Tc        (Tc),
      .Done      (Done)
   );

   // Clock and reset: active edge is the falling edge, outputs sampled on the rising edge.
   initial Clk = 1'b1;
   always #5 Clk = ~Clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge Clk);
      @(posedge Clk);
   endtask

   task automatic push_exp(input logic [W-1:0] c, input logic t, input logic d);
      exp_q.push_back({c, t, d});
   endtask

   task automatic test_reset();
      logic [W+1:0] e;
      nReset = 1'b0; Clear = 1'b0; Load = 1'b0; Count_en = 1'b1; Up = 1'b1;
      Mode = 2'b00; Limit = 8'd5; Count_in = 8'h55;
      push_exp(8'd0, 1'b0, 1'b0);
      tick();
      e = exp_q.pop_front(); n_checks++;
      if ({Count_out, Tc, Done} !== e) begin
         n_fails++;
         $display("FAIL reset: got cnt=%0h tc=%0b done=%0b, expected cnt=%0h tc=%0b done=%0b",
                  Count_out, Tc, Done, e[W+1:2], e[1], e[0]);
      end
      Count_en = 1'b0;
      nReset = 1'b1;
   endtask

   task automatic test_wrap();
      logic [W+1:0] e;
      int cnts[7] = '{1, 2, 3, 4, 5, 0, 1};
      Limit = 8'd5; Mode = 2'b00; Up = 1'b1; Count_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         push_exp(W'(cnts[i]), (i == 5), 1'b0);
         tick();
         e = exp_q.pop_front(); n_checks++;
         if ({Count_out, Tc, Done} !== e) begin
            n_fails++;
            $display("FAIL wrap[%0d]: got cnt=%0h tc=%0b done=%0b, expected cnt=%0h tc=%0b done=%0b",
                     i, Count_out, Tc, Done, e[W+1:2], e[1], e[0]);
         end
      end
   endtask

   task automatic test_saturate();
      logic [W+1:0] e;
      int cnts[5] = '{2, 1, 0, 0, 0};
      int tcs[5]  = '{0, 0, 0, 1, 1};
      Mode = 2'b01; Up = 1'b0; Count_en = 1'b1; Count_in = 8'd2;
      for (int i = 0; i < 5; i++) begin
         Load = (i == 0);
         push_exp(W'(cnts[i]), tcs[i][0], 1'b0);
         tick();
         e = exp_q.pop_front(); n_checks++;
         if ({Count_out, Tc, Done} !== e) begin
            n_fails++;
            $display("FAIL saturate[%0d]: got cnt=%0h tc=%0b done=%0b, expected cnt=%0h tc=%0b done=%0b",
                     i, Count_out, Tc, Done, e[W+1:2], e[1], e[0]);
         end
      end
      Load = 1'b0;
   endtask

   task automatic test_oneshot();
      logic [W+1:0] e;
      // per step: clear, load, mode, expected count, tc, done
      int tbl[11][6] = '{
         '{1, 0, 2, 0, 0, 0},
         '{0, 0, 2, 1, 0, 0},
         '{0, 0, 2, 2, 0, 0},
         '{0, 0, 2, 3, 0, 0},
         '{0, 0, 2, 3, 1, 1},
         '{0, 0, 2, 3, 0, 1},
         '{0, 0, 2, 3, 0, 1},
         '{0, 0, 0, 0, 1, 1},
         '{0, 0, 0, 1, 0, 1},
         '{0, 1, 2, 0, 0, 0},
         '{0, 0, 2, 1, 0, 0}
      };
      Limit = 8'd3; Up = 1'b1; Count_en = 1'b1; Count_in = 8'd0;
      for (int i = 0; i < 11; i++) begin
         Clear = tbl[i][0][0];
         Load  = tbl[i][1][0];
         Mode  = tbl[i][2][1:0];
         push_exp(W'(tbl[i][3]), tbl[i][4][0], tbl[i][5][0]);
         tick();
         e = exp_q.pop_front(); n_checks++;
         if ({Count_out, Tc, Done} !== e) begin
            n_fails++;
            $display("FAIL oneshot[%0d]: got cnt=%0h tc=%0b done=%0b, expected cnt=%0h tc=%0b done=%0b",
                     i, Count_out, Tc, Done, e[W+1:2], e[1], e[0]);
         end
      end
      Clear = 1'b0; Load = 1'b0;
   endtask

   task automatic test_priority();
      logic [W+1:0] e;
      // per step: clear, load, up, expected count, tc
      int tbl[5][5] = '{
         '{1, 1, 1, 8'h00, 0},
         '{0, 1, 1, 8'h7A, 0},
         '{0, 0, 1, 8'h00, 1},
         '{0, 1, 0, 8'h7A, 0},
         '{0, 0, 0, 8'h79, 0}
      };
      Limit = 8'd3; Mode = 2'b00; Count_en = 1'b1; Count_in = 8'h7A;
      for (int i = 0; i < 5; i++) begin
         Clear = tbl[i][0][0];
         Load  = tbl[i][1][0];
         Up    = tbl[i][2][0];
         push_exp(W'(tbl[i][3]), tbl[i][4][0], 1'b0);
         tick();
         e = exp_q.pop_front(); n_checks++;
         if ({Count_out, Tc, Done} !== e) begin
            n_fails++;
            $display("FAIL priority[%0d]: got cnt=%0h tc=%0b done=%0b, expected cnt=%0h tc=%0b done=%0b",
                     i, Count_out, Tc, Done, e[W+1:2], e[1], e[0]);
         end
      end
      Clear = 1'b0; Load = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [W+1:0] e;
      Limit = 8'h40; Mode = 2'b10; Up = 1'b1; Count_en = 1'b1; Count_in = 8'h3F;
      Load = 1'b1;
      push_exp(8'h3F, 1'b0, 1'b0);
      tick();
      Load = 1'b0;
      push_exp(8'h40, 1'b0, 1'b0);
      tick();
      push_exp(8'h40, 1'b1, 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         e = exp_q.pop_front(); n_checks++;
         if (e[W+1:2] == 8'h40 && e[1] && (Count_out !== 8'h40 || Tc !== 1'b1 || Done !== 1'b1)) begin
            n_fails++;
            $display("FAIL areset_pre: got cnt=%0h tc=%0b done=%0b, expected cnt=40 tc=1 done=1",
                     Count_out, Tc, Done);
         end
      end
      // Reset asserted between falling edges must clear outputs immediately.
      #3 nReset = 1'b0;
      push_exp(8'h00, 1'b0, 1'b0);
      #1;
      e = exp_q.pop_front(); n_checks++;
      if ({Count_out, Tc, Done} !== e) begin
         n_fails++;
         $display("FAIL areset_now: got cnt=%0h tc=%0b done=%0b, expected cnt=%0h tc=%0b done=%0b",
                  Count_out, Tc, Done, e[W+1:2], e[1], e[0]);
      end
      push_exp(8'h00, 1'b0, 1'b0);
      tick();
      e = exp_q.pop_front(); n_checks++;
      if ({Count_out, Tc, Done} !== e) begin
         n_fails++;
         $display("FAIL areset_hold: got cnt=%0h tc=%0b done=%0b, expected cnt=%0h tc=%0b done=%0b",
                  Count_out, Tc, Done, e[W+1:2], e[1], e[0]);
      end
      nReset = 1'b1;
      push_exp(W'(PS == 1 ? 1 : 0), 1'b0, 1'b0);
      tick();
      e = exp_q.pop_front(); n_checks++;
      if ({Count_out, Tc, Done} !== e) begin
         n_fails++;
         $display("FAIL areset_resume: got cnt=%0h tc=%0b done=%0b, expected cnt=%0h tc=%0b done=%0b",
                  Count_out, Tc, Done, e[W+1:2], e[1], e[0]);
      end
   endtask

   task automatic test_limit_zero();
      logic [W+1:0] e;
      // per step: clear, up, en, expected tc
      int tbl[7][4] = '{
         '{1, 1, 1, 0},
         '{0, 1, 1, 1},
         '{0, 1, 1, 1},
         '{0, 1, 1, 1},
         '{0, 0, 1, 1},
         '{0, 0, 1, 1},
         '{0, 0, 0, 0}
      };
      Limit = 8'd0; Mode = 2'b11;
      for (int i = 0; i < 7; i++) begin
         Clear    = tbl[i][0][0];
         Up       = tbl[i][1][0];
         Count_en = tbl[i][2][0];
         push_exp(8'd0, tbl[i][3][0], 1'b0);
         tick();
         e = exp_q.pop_front(); n_checks++;
         if ({Count_out, Tc, Done} !== e) begin
            n_fails++;
            $display("FAIL limit_zero[%0d]: got cnt=%0h tc=%0b done=%0b, expected cnt=%0h tc=%0b done=%0b",
                     i, Count_out, Tc, Done, e[W+1:2], e[1], e[0]);
         end
      end
      Clear = 1'b0;
   endtask

   task automatic test_prescaler();
      logic [W+1:0] e;
      // per step: clear, en, expected count, tc
      int tbl[16][4] = '{
         '{1, 1, 0, 0},
         '{0, 1, 0, 0}, '{0, 1, 0, 0}, '{0, 1, 0, 0}, '{0, 1, 1, 0},
         '{0, 1, 1, 0}, '{0, 1, 1, 0}, '{0, 1, 1, 0}, '{0, 1, 2, 0},
         '{0, 0, 2, 0}, '{0, 0, 2, 0}, '{0, 0, 2, 0},
         '{0, 1, 2, 0}, '{0, 1, 2, 0}, '{0, 1, 2, 0}, '{0, 1, 3, 0}
      };
      Limit = 8'd9; Mode = 2'b00; Up = 1'b1;
      for (int i = 0; i < 16; i++) begin
         Clear    = tbl[i][0][0];
         Count_en = tbl[i][1][0];
         push_exp(W'(tbl[i][2]), tbl[i][3][0], 1'b0);
         tick();
         e = exp_q.pop_front(); n_checks++;
         if ({Count_out, Tc, Done} !== e) begin
            n_fails++;
            $display("FAIL prescaler[%0d]: got cnt=%0h tc=%0b done=%0b, expected cnt=%0h tc=%0b done=%0b",
                     i, Count_out, Tc, Done, e[W+1:2], e[1], e[0]);
         end
      end
      Clear = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [W+1:0] e;
      logic [W-1:0] m_cnt;
      logic         m_tc;
      logic         m_done;
      int           m_pre;
      logic         ev;
      m_cnt = '0; m_tc = 1'b0; m_done = 1'b0; m_pre = 0;
      for (int i = 0; i < 400; i++) begin
         Clear    = (i == 0) || ($urandom_range(0, 19) == 0);
         Load     = ($urandom_range(0, 15) == 0);
         Count_en = ($urandom_range(0, 3) != 0);
         Up       = $urandom_range(0, 1) != 0;
         if (i % 25 == 0) Mode = 2'($urandom_range(0, 3));
         if (i % 40 == 0) Limit = ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom_range(0, 12));
         Count_in = ($urandom_range(0, 7) == 0) ? 8'hF0 : W'($urandom_range(0, 14));
         if (Clear) begin
            m_cnt = '0; m_tc = 1'b0; m_done = 1'b0; m_pre = 0;
         end else if (Load) begin
            m_cnt = Count_in; m_tc = 1'b0; m_done = 1'b0; m_pre = 0;
         end else begin
            ev = Count_en && !(Mode == 2'b10 && m_done) && (m_pre == PS - 1);
            if (Count_en) m_pre = (m_pre == PS - 1) ? 0 : m_pre + 1;
            m_tc = 1'b0;
            if (ev && Up) begin
               if (m_cnt >= Limit) begin
                  m_tc = 1'b1;
                  if (Mode == 2'b01) m_cnt = Limit;
                  else if (Mode == 2'b10) begin m_cnt = Limit; m_done = 1'b1; end
                  else m_cnt = '0;
               end else begin
                  m_cnt = m_cnt + 8'd1;
               end
            end else if (ev) begin
               if (m_cnt == 0) begin
                  m_tc = 1'b1;
                  if (Mode == 2'b10) m_done = 1'b1;
                  else if (Mode != 2'b01) m_cnt = Limit;
               end else begin
                  m_cnt = m_cnt - 8'd1;
               end
            end
         end
         push_exp(m_cnt, m_tc, m_done);
         tick();
         e = exp_q.pop_front(); n_checks++;
         if ({Count_out, Tc, Done} !== e) begin
            n_fails++;
            $display("FAIL random[%0d]: got cnt=%0h tc=%0b done=%0b, expected cnt=%0h tc=%0b done=%0b",
                     i, Count_out, Tc, Done, e[W+1:2], e[1], e[0]);
         end
      end
      Clear = 1'b0; Load = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      test_reset();
`ifdef COUNTER_PRESCALER_EN
      test_prescaler();
`else
      test_wrap();
      test_saturate();
      test_oneshot();
      test_priority();
      test_async_reset();
      test_limit_zero();
`endif
      test_back_to_back();
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
      end
      n_checks++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
